// File: rtl/hvac_pkg.sv
// Shared encodings for the HVAC sequencer: FSM states, input codes and the fan duty table.
// Duty values are out of 256, so 256 means the fan is always on.
package hvac_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_HEAT  = 2'b01,
    ST_COOL  = 2'b10,
    ST_DWELL = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_MANUAL = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    HCS_HEAT = 2'b00,
    HCS_COOL = 2'b01,
    HCS_STOP = 2'b10,
    HCS_RSVD = 2'b11
  } hcs_e;

  typedef enum logic [1:0] {
    LVL_0 = 2'b00,
    LVL_1 = 2'b01,
    LVL_2 = 2'b10,
    LVL_3 = 2'b11
  } level_e;

  localparam logic [8:0] DUTY_L0        = 9'd64;
  localparam logic [8:0] DUTY_L1        = 9'd128;
  localparam logic [8:0] DUTY_L2        = 9'd192;
  localparam logic [8:0] DUTY_L3        = 9'd256;
  localparam logic [8:0] DUTY_QUIET_CAP = 9'd128;
  localparam logic [8:0] DUTY_RUNDOWN   = 9'd64;

  // Level sets the base duty, quiet mode caps it, and IDLE turns the fan off
  // except while dwelling, where a minimum run-down airflow is kept.
  function automatic logic [8:0] fan_duty(input logic [1:0] level,
                                          input logic       quiet,
                                          input logic       idle,
                                          input logic       dwell);
    logic [8:0] d;
    case (level)
      LVL_0:   d = DUTY_L0;
      LVL_1:   d = DUTY_L1;
      LVL_2:   d = DUTY_L2;
      default: d = DUTY_L3;
    endcase
    if (quiet && (d > DUTY_QUIET_CAP)) d = DUTY_QUIET_CAP;
    if (idle) d = dwell ? ((d < DUTY_RUNDOWN) ? DUTY_RUNDOWN : d) : 9'd0;
    return d;
  endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// Free-running 8-bit PWM for the fan; output is high while the counter is below duty.
// A 9-bit duty lets 256 express a fan that never switches off.
module fan_pwm_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] duty,
  output logic       pwm
);

  logic [7:0] r_cnt;
  logic       r_pwm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 8'd0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
      r_pwm <= ({1'b0, r_cnt} < duty);
    end
  end

  assign pwm = r_pwm;

endmodule

// File: rtl/hvac_sequencer.sv
// HVAC run sequencer: OFF -> HEAT/COOL -> DWELL -> OFF with a minimum on-time and a
// guard dwell between runs, plus level-driven fan PWM.
module hvac_sequencer
  import hvac_pkg::*;
#(
  parameter int MIN_ON_TICKS = 60,
  parameter int GUARD_TICKS  = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] mode,
  input  logic [1:0] heat_cool_stop,
  input  logic [1:0] level,
  input  logic       ultrasonic_mode,
  output logic       heater_en,
  output logic       cooler_en,
  output logic       fan_pwm,
  output logic [1:0] state
);

  localparam logic [7:0] MIN_ON_LOAD = 8'(MIN_ON_TICKS);
  localparam logic [7:0] GUARD_LOAD  = 8'(GUARD_TICKS);

  state_e     r_state;
  logic [7:0] r_tcnt;
  logic       r_heater_en;
  logic       r_cooler_en;

  logic       w_idle;
  logic       w_tcnt_zero;
  logic [8:0] w_duty;

  // The reserved mode code behaves exactly like IDLE.
  assign w_idle      = (mode == MODE_IDLE) || (mode == MODE_RSVD);
  assign w_tcnt_zero = (r_tcnt == 8'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_OFF;
      r_tcnt      <= 8'd0;
      r_heater_en <= 1'b0;
      r_cooler_en <= 1'b0;
    end else begin
      // Enables follow the state register one clock later, so both can never be high.
      r_heater_en <= (r_state == ST_HEAT);
      r_cooler_en <= (r_state == ST_COOL);

      // NOTE: non-blocking assignments let the later entry loads in the case below
      // override this decrement, which is how an entry beats a coincident tick.
      if (tick && !w_tcnt_zero) r_tcnt <= r_tcnt - 8'd1;

      case (r_state)
        ST_OFF: begin
          if (!w_idle) begin
            if (heat_cool_stop == HCS_HEAT) begin
              r_state <= ST_HEAT;
              r_tcnt  <= MIN_ON_LOAD;
            end else if (heat_cool_stop == HCS_COOL) begin
              r_state <= ST_COOL;
              r_tcnt  <= MIN_ON_LOAD;
            end
          end
        end
        ST_HEAT: begin
          if (w_idle || (w_tcnt_zero && (heat_cool_stop != HCS_HEAT))) begin
            r_state <= ST_DWELL;
            r_tcnt  <= GUARD_LOAD;
          end
        end
        ST_COOL: begin
          if (w_idle || (w_tcnt_zero && (heat_cool_stop != HCS_COOL))) begin
            r_state <= ST_DWELL;
            r_tcnt  <= GUARD_LOAD;
          end
        end
        default: begin
          if (w_tcnt_zero) r_state <= ST_OFF;
        end
      endcase
    end
  end

  assign w_duty = fan_duty(level, ultrasonic_mode, w_idle, r_state == ST_DWELL);

  fan_pwm_gen u_fan_pwm_gen (
    .clk   (clk),
    .reset (reset),
    .duty  (w_duty),
    .pwm   (fan_pwm)
  );

  assign heater_en = r_heater_en;
  assign cooler_en = r_cooler_en;
  assign state     = r_state;

endmodule
